// File: rtl/ps2_host_tx.sv
`default_nettype none
// ==========================================================================
// ps2_host_tx : PS/2 host-to-device byte transmitter (inhibit, ack, watchdog)
// Revision 1.0
// ==========================================================================
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       CLOCK_50,
  input  logic       frame_reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_busy,
  output logic       tx_done_tick,
  output logic       tx_err_tick
);

  localparam int          FW           = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FW-1:0] FILTER_LAST  = FW'(FILTER_LEN - 1);
  localparam logic [19:0] INHIBIT_LAST = 20'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RTS       = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    PARITY    = 3'd4,
    STOP      = 3'd5,
    ACK       = 3'd6,
    WAIT_IDLE = 3'd7
  } state_t;

  logic [1:0]    c_sync;
  logic [1:0]    d_sync;
  logic          c_filt;
  logic [FW-1:0] filt_cnt;
  logic          fall_tick;

  state_t        state;
  logic [7:0]    data;
  logic          parity;
  logic [2:0]    idx;
  logic          ack;
  logic [19:0]   rts_cnt;
  logic [19:0]   wd_cnt;
  logic          wd_live;
  logic          timeout;

  always_ff @(posedge CLOCK_50 or posedge frame_reset) begin
    if (frame_reset) begin
      c_sync <= 2'b11;
      d_sync <= 2'b11;
    end else begin
      c_sync <= {c_sync[0], ps2c_in};
      d_sync <= {d_sync[0], ps2d_in};
    end
  end

  // Filtered clock flips only after FILTER_LEN samples in a row disagree with it.
  always_ff @(posedge CLOCK_50 or posedge frame_reset) begin
    if (frame_reset) begin
      c_filt    <= 1'b1;
      filt_cnt  <= '0;
      fall_tick <= 1'b0;
    end else begin
      fall_tick <= 1'b0;
      if (c_sync[1] == c_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILTER_LAST) begin
        filt_cnt  <= '0;
        c_filt    <= c_sync[1];
        fall_tick <= c_filt;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  assign wd_live = state inside {START, DATA, PARITY, STOP, ACK, WAIT_IDLE};
  assign timeout = wd_live && !fall_tick && (wd_cnt == TIMEOUT_LAST);

  always_ff @(posedge CLOCK_50 or posedge frame_reset) begin
    if (frame_reset) begin
      state        <= IDLE;
      data         <= 8'd0;
      parity       <= 1'b0;
      idx          <= 3'd0;
      ack          <= 1'b0;
      rts_cnt      <= 20'd0;
      wd_cnt       <= 20'd0;
      ps2c_oe      <= 1'b0;
      ps2d_oe      <= 1'b0;
      tx_busy      <= 1'b0;
      tx_done_tick <= 1'b0;
      tx_err_tick  <= 1'b0;
    end else begin
      tx_done_tick <= 1'b0;
      tx_err_tick  <= 1'b0;

      if (!wd_live || fall_tick) wd_cnt <= 20'd0;
      else if (wd_cnt != 20'hFFFFF) wd_cnt <= wd_cnt + 20'd1;

      if (timeout) begin
        state       <= IDLE;
        ps2c_oe     <= 1'b0;
        ps2d_oe     <= 1'b0;
        tx_busy     <= 1'b0;
        ack         <= 1'b0;
        tx_err_tick <= 1'b1;
      end else begin
        case (state)
          IDLE: if (tx_start) begin
            data    <= tx_data;
            parity  <= ~^tx_data;
            rts_cnt <= 20'd0;
            ack     <= 1'b0;
            ps2c_oe <= 1'b1;
            ps2d_oe <= 1'b0;
            tx_busy <= 1'b1;
            state   <= RTS;
          end
          RTS: begin
            if (rts_cnt == INHIBIT_LAST) begin
              ps2c_oe <= 1'b0;
              ps2d_oe <= 1'b1;
              state   <= START;
            end else if (rts_cnt != 20'hFFFFF) begin
              rts_cnt <= rts_cnt + 20'd1;
            end
          end
          START: if (fall_tick) begin
            idx     <= 3'd0;
            ps2d_oe <= ~data[0];
            state   <= DATA;
          end
          DATA: if (fall_tick) begin
            if (idx == 3'd7) begin
              ps2d_oe <= ~parity;
              state   <= PARITY;
            end else begin
              idx     <= idx + 3'd1;
              ps2d_oe <= ~data[idx + 3'd1];
            end
          end
          PARITY: if (fall_tick) begin
            ps2d_oe <= 1'b0;
            state   <= STOP;
          end
          STOP: if (fall_tick) state <= ACK;
          ACK: if (fall_tick) begin
            if (!d_sync[1]) begin
              ack   <= 1'b1;
              state <= WAIT_IDLE;
            end else begin
              tx_err_tick <= 1'b1;
              tx_busy     <= 1'b0;
              state       <= IDLE;
            end
          end
          WAIT_IDLE: if (ack && c_filt && d_sync[1]) begin
            tx_done_tick <= 1'b1;
            tx_busy      <= 1'b0;
            ack          <= 1'b0;
            state        <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ==========================================================================
// tb_ps2_host_tx : directed bench with a simple PS/2 device model
// Revision 1.0
// ==========================================================================
module tb_ps2_host_tx;

  localparam int INH  = 100;
  localparam int TO   = 300;
  localparam int FILT = 8;
  localparam int HALF = 20;

  logic       CLOCK_50    = 1'b0;
  logic       frame_reset = 1'b1;
  logic       tx_start    = 1'b0;
  logic [7:0] tx_data     = 8'd0;
  logic       dev_c       = 1'b1;
  logic       dev_d       = 1'b1;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_oe, ps2d_oe, tx_busy, tx_done_tick, tx_err_tick;

  int checks = 0, failures = 0;
  int done_total = 0, err_total = 0, busy_bad = 0, both_cnt = 0;

  // Open-drain bus: either side can pull a line low.
  assign ps2c_in = dev_c & ~ps2c_oe;
  assign ps2d_in = dev_d & ~ps2d_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN    (FILT)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .frame_reset (frame_reset),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .ps2c_in     (ps2c_in),
    .ps2d_in     (ps2d_in),
    .ps2c_oe     (ps2c_oe),
    .ps2d_oe     (ps2d_oe),
    .tx_busy     (tx_busy),
    .tx_done_tick(tx_done_tick),
    .tx_err_tick (tx_err_tick)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) begin
    if (tx_done_tick === 1'b1) done_total++;
    if (tx_err_tick === 1'b1) err_total++;
    if ((tx_done_tick === 1'b1 || tx_err_tick === 1'b1) && tx_busy !== 1'b0) busy_bad++;
    if (tx_done_tick === 1'b1 && tx_err_tick === 1'b1) both_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit ack, input bit glitch,
                            input int abort_at, output logic [9:0] bits, output int inh);
    bits = '0;
    inh  = 0;
    tx_data  = b;
    tx_start = 1'b1;
    cyc(1);
    tx_start = 1'b0;
    chk("rts_busy", {31'd0, tx_busy}, 32'd1);
    chk("rts_d_oe", {31'd0, ps2d_oe}, 32'd0);
    while (ps2c_oe === 1'b1 && inh < INH + 50) begin
      inh++;
      cyc(1);
    end
    chk("start_d_oe", {31'd0, ps2d_oe}, 32'd1);
    cyc(HALF);
    for (int k = 1; k <= 12; k++) begin
      dev_c = 1'b0;
      if (glitch && (k == 3 || k == 11)) begin
        tx_start = 1'b1;
        tx_data  = ~b;
      end
      cyc(1);
      tx_start = 1'b0;
      cyc(HALF - 2);
      if (k <= 10) bits[k-1] = ps2d_oe;
      if (k == abort_at) begin
        #2 frame_reset = 1'b1;
        #1;
        chk("abort_c_oe", {31'd0, ps2c_oe}, 32'd0);
        chk("abort_d_oe", {31'd0, ps2d_oe}, 32'd0);
        chk("abort_busy", {31'd0, tx_busy}, 32'd0);
        chk("abort_ticks", {30'd0, tx_done_tick, tx_err_tick}, 32'd0);
        return;
      end
      cyc(1);
      dev_c = 1'b1;
      if (k == 11 && ack) dev_d = 1'b0;
      if (k == 12) dev_d = 1'b1;
      if (glitch) begin
        cyc(14);
        dev_c = 1'b0;
        cyc(3);
        dev_c = 1'b1;
        cyc(3);
      end else begin
        cyc(HALF);
      end
    end
  endtask

  initial begin
    logic [9:0] bits;
    int inh, n, d0, e0;

    cyc(3);
    chk("reset_c_oe", {31'd0, ps2c_oe}, 32'd0);
    chk("reset_d_oe", {31'd0, ps2d_oe}, 32'd0);
    chk("reset_busy", {31'd0, tx_busy}, 32'd0);
    chk("reset_ticks", {30'd0, tx_done_tick, tx_err_tick}, 32'd0);
    frame_reset = 1'b0;
    cyc(20);

    // 0xED acked: data oe 0,1,0,0,1,0,0,0; parity 1 -> oe 0; stop oe 0
    d0 = done_total; e0 = err_total;
    send_frame(8'hED, 1'b1, 1'b0, 0, bits, inh);
    cyc(100);
    chk("ed_inhibit", inh, INH);
    chk("ed_bits", {22'd0, bits}, 32'h012);
    chk("ed_done", done_total - d0, 32'd1);
    chk("ed_err", err_total - e0, 32'd0);
    chk("ed_busy_after", {31'd0, tx_busy}, 32'd0);

    // 0x00 acked: data oe all 1, parity 1 -> oe 0
    d0 = done_total; e0 = err_total;
    send_frame(8'h00, 1'b1, 1'b0, 0, bits, inh);
    cyc(100);
    chk("zero_bits", {22'd0, bits}, 32'h0FF);
    chk("zero_done", done_total - d0, 32'd1);
    chk("zero_err", err_total - e0, 32'd0);

    // 0x5A, device never acks
    d0 = done_total; e0 = err_total;
    send_frame(8'h5A, 1'b0, 1'b0, 0, bits, inh);
    cyc(100);
    chk("nack_bits", {22'd0, bits}, 32'h0A5);
    chk("nack_done", done_total - d0, 32'd0);
    chk("nack_err", err_total - e0, 32'd1);
    chk("nack_busy", {31'd0, tx_busy}, 32'd0);

    // Device never clocks: error exactly TO cycles after START entry
    d0 = done_total; e0 = err_total;
    tx_data  = 8'h81;
    tx_start = 1'b1;
    cyc(1);
    tx_start = 1'b0;
    n = 0;
    while (ps2c_oe === 1'b1 && n < INH + 50) begin
      n++;
      cyc(1);
    end
    n = 0;
    while (tx_err_tick !== 1'b1 && n < TO + 100) begin
      cyc(1);
      n++;
    end
    chk("to_latency", n, TO);
    chk("to_c_oe", {31'd0, ps2c_oe}, 32'd0);
    chk("to_d_oe", {31'd0, ps2d_oe}, 32'd0);
    chk("to_busy", {31'd0, tx_busy}, 32'd0);
    cyc(5);
    chk("to_err", err_total - e0, 32'd1);
    chk("to_done", done_total - d0, 32'd0);

    // Reset during DATA bit 4 of 0xA5 (bit4 = 0 -> oe 1), then a clean 0x07
    d0 = done_total; e0 = err_total;
    send_frame(8'hA5, 1'b1, 1'b0, 5, bits, inh);
    chk("abort_pre_oe", {31'd0, bits[4]}, 32'd1);
    cyc(2);
    dev_c = 1'b1;
    dev_d = 1'b1;
    cyc(5);
    frame_reset = 1'b0;
    cyc(30);
    chk("abort_no_done", done_total - d0, 32'd0);
    chk("abort_no_err", err_total - e0, 32'd0);
    d0 = done_total; e0 = err_total;
    send_frame(8'h07, 1'b1, 1'b0, 0, bits, inh);
    cyc(100);
    chk("post_rst_bits", {22'd0, bits}, 32'h1F8);
    chk("post_rst_done", done_total - d0, 32'd1);
    chk("post_rst_err", err_total - e0, 32'd0);

    // tx_start while busy plus 3-cycle clock glitches on 0x3C
    d0 = done_total; e0 = err_total;
    send_frame(8'h3C, 1'b1, 1'b1, 0, bits, inh);
    cyc(100);
    chk("glitch_bits", {22'd0, bits}, 32'h0C3);
    chk("glitch_done", done_total - d0, 32'd1);
    chk("glitch_err", err_total - e0, 32'd0);
    chk("glitch_no_restart_busy", {31'd0, tx_busy}, 32'd0);
    chk("glitch_no_restart_c_oe", {31'd0, ps2c_oe}, 32'd0);

    chk("busy_low_at_tick", busy_bad, 32'd0);
    chk("ticks_exclusive", both_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
